// File: rtl/stack_mem_ctrl_pkg.sv
// Shared constants for the stack calculator scratch-memory controller:
// memory width, memory mode codes, command op codes and FSM state encodings.
`ifndef MEMORY_ADDR_BITS
`define MEMORY_ADDR_BITS 4
`endif

package stack_mem_ctrl_pkg;

  localparam int MEMORY_ADDR_BITS = `MEMORY_ADDR_BITS;
  localparam int NIBBLE_W         = 4;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_CLEAR = 2'd1,
    MODE_WRITE = 2'd2,
    MODE_READ  = 2'd3
  } mem_mode_e;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'd0,
    OP_POP   = 2'd1,
    OP_PEEK  = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ      = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_CLEAR     = 3'd4,
    ST_RESP      = 3'd5,
    ST_INIT      = 3'd6
  } state_e;

endpackage

// File: rtl/stack_mem_ctrl.sv
// Stack controller for the calculator scratch memory: FSM plus stack pointer.
// Define STACK_MEM_CTRL_CLEAR_ON_RESET_EN to clear the memory once after reset.
module stack_mem_ctrl
  import stack_mem_ctrl_pkg::*;
#(
  parameter int ADDR_BITS = MEMORY_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [NIBBLE_W-1:0]  cmd_data,
  output logic                 rsp_valid,
  output logic [NIBBLE_W-1:0]  rsp_data,
  output logic                 rsp_err,
  output logic [1:0]           mem_mode,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [NIBBLE_W-1:0]  mem_data_in,
  input  logic [NIBBLE_W-1:0]  mem_data_out,
  output logic [ADDR_BITS:0]   depth,
  output logic                 empty,
  output logic                 full
);

`ifdef STACK_MEM_CTRL_CLEAR_ON_RESET_EN
  localparam state_e     RST_STATE = ST_INIT;
  localparam logic [1:0] RST_MODE  = MODE_CLEAR;
  localparam logic       RST_READY = 1'b0;
`else
  localparam state_e     RST_STATE = ST_IDLE;
  localparam logic [1:0] RST_MODE  = MODE_NONE;
  localparam logic       RST_READY = 1'b1;
`endif

  localparam logic [ADDR_BITS:0] SP_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

  state_e               state;
  cmd_op_e              op_q;
  logic [ADDR_BITS:0]   sp;
  logic [ADDR_BITS:0]   sp_dec;

  // sp never exceeds capacity, so its MSB alone marks a full stack
  assign depth  = sp;
  assign empty  = (sp == '0);
  assign full   = sp[ADDR_BITS];
  assign sp_dec = sp - SP_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RST_STATE;
      op_q        <= OP_PUSH;
      sp          <= '0;
      cmd_ready   <= RST_READY;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      mem_mode    <= RST_MODE;
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else begin
      rsp_valid <= 1'b0;
      mem_mode  <= MODE_NONE;
      case (state)
        ST_INIT: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op_e'(cmd_op);
            cmd_ready <= 1'b0;
            case (cmd_op)
              OP_PUSH: begin
                if (full) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                end else begin
                  state       <= ST_WRITE;
                  mem_mode    <= MODE_WRITE;
                  mem_addr    <= sp[ADDR_BITS-1:0];
                  mem_data_in <= cmd_data;
                end
              end
              OP_POP, OP_PEEK: begin
                if (empty) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                end else begin
                  state    <= ST_READ;
                  mem_mode <= MODE_READ;
                  mem_addr <= sp_dec[ADDR_BITS-1:0];
                end
              end
              default: begin
                state    <= ST_CLEAR;
                mem_mode <= MODE_CLEAR;
              end
            endcase
          end
        end
        ST_WRITE: begin
          sp        <= sp + SP_ONE;
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
        end
        ST_READ: begin
          state <= ST_READ_WAIT;
        end
        // memory presents the read nibble during this state
        ST_READ_WAIT: begin
          rsp_data  <= mem_data_out;
          if (op_q == OP_POP) sp <= sp_dec;
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
        end
        ST_CLEAR: begin
          sp        <= '0;
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          rsp_err   <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed bench for stack_mem_ctrl with a behavioural scratch memory (1-cycle read latency).
module tb_stack_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [1:0] mem_mode;
  logic [3:0] mem_addr;
  logic [3:0] mem_data_in;
  logic [3:0] mem_data_out;
  logic [4:0] depth;
  logic       empty;
  logic       full;

  logic [3:0] mem [16];
  int         act_cnt = 0;
  int         clr_cnt = 0;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  stack_mem_ctrl #(.ADDR_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .depth(depth), .empty(empty), .full(full)
  );

  always @(posedge clk) begin
    case (mem_mode)
      2'd1: for (int i = 0; i < 16; i++) mem[i] <= 4'h0;
      2'd2: mem[mem_addr] <= mem_data_in;
      2'd3: mem_data_out <= mem[mem_addr];
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if (mem_mode != 2'd0) act_cnt <= act_cnt + 1;
    if (mem_mode == 2'd1) clr_cnt <= clr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one command from a negedge; returns cycles from handshake edge to rsp_valid.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] d,
                        output int lat, output logic err, output logic [3:0] rd);
    int guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    err = 1'b0;
    rd  = 4'h0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        err = rsp_err;
        rd  = rsp_data;
        break;
      end
    end
  endtask

  int         lat;
  logic       err;
  logic [3:0] rd;
  int         base;
  logic       saw;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 4'h0;
    repeat (2) @(negedge clk);
`ifdef STACK_MEM_CTRL_CLEAR_ON_RESET_EN
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_mode", mem_mode, 2'd1);
`else
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_mode", mem_mode, 2'd0);
`endif
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 4'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_addr", mem_addr, 4'h0);
    check("rst_din", mem_data_in, 4'h0);
    check("rst_depth", depth, 5'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // push 3, A, 5
    do_cmd(2'd0, 4'h3, lat, err, rd); check("push0_lat", lat, 2); check("push0_err", err, 0);
    do_cmd(2'd0, 4'hA, lat, err, rd); check("push1_lat", lat, 2); check("push1_err", err, 0);
    do_cmd(2'd0, 4'h5, lat, err, rd); check("push2_lat", lat, 2); check("push2_err", err, 0);
    check("push_depth", depth, 5'd3);
    check("mem0", mem[0], 4'h3);
    check("mem1", mem[1], 4'hA);
    check("mem2", mem[2], 4'h5);

    // peek, pop x3
    do_cmd(2'd2, 4'h0, lat, err, rd);
    check("peek_lat", lat, 3); check("peek_data", rd, 4'h5); check("peek_depth", depth, 5'd3);
    do_cmd(2'd1, 4'h0, lat, err, rd);
    check("pop0_lat", lat, 3); check("pop0_data", rd, 4'h5); check("pop0_err", err, 0);
    @(negedge clk); check("pop0_depth", depth, 5'd2);
    do_cmd(2'd1, 4'h0, lat, err, rd);
    check("pop1_data", rd, 4'hA); @(negedge clk); check("pop1_depth", depth, 5'd1);
    do_cmd(2'd1, 4'h0, lat, err, rd);
    check("pop2_data", rd, 4'h3); @(negedge clk); check("pop2_depth", depth, 5'd0);
    check("pop2_empty", empty, 1'b1);

    // underflow
    base = act_cnt;
    do_cmd(2'd1, 4'h0, lat, err, rd);
    check("uflow_lat", lat, 1); check("uflow_err", err, 1); check("uflow_data", rd, 4'h3);
    check("uflow_mode", act_cnt - base, 0);
    check("uflow_depth", depth, 5'd0);

    // fill to capacity
    for (int i = 0; i < 16; i++) do_cmd(2'd0, 4'((i * 5 + 2) & 15), lat, err, rd);
    @(negedge clk);
    check("fill_full", full, 1'b1); check("fill_depth", depth, 5'd16);
    do_cmd(2'd0, 4'hE, lat, err, rd);
    check("oflow_lat", lat, 1); check("oflow_err", err, 1);
    @(negedge clk); check("oflow_depth", depth, 5'd16);
    do_cmd(2'd1, 4'h0, lat, err, rd);
    check("last_pop_data", rd, 4'hD);
    @(negedge clk); check("last_pop_depth", depth, 5'd15);

    // clear from 15, refill to 5, clear again
    do_cmd(2'd3, 4'h0, lat, err, rd); check("clr0_lat", lat, 2);
    for (int i = 0; i < 5; i++) do_cmd(2'd0, 4'(i + 1), lat, err, rd);
    @(negedge clk); check("five_depth", depth, 5'd5);
    base = clr_cnt;
    do_cmd(2'd3, 4'h0, lat, err, rd);
    check("clr1_lat", lat, 2); check("clr1_err", err, 0);
    check("clr1_cycles", clr_cnt - base, 1);
    @(negedge clk); check("clr1_depth", depth, 5'd0);
    do_cmd(2'd1, 4'h0, lat, err, rd);
    check("clr_pop_lat", lat, 1); check("clr_pop_err", err, 1);

    // reset during READ of a pop
    do_cmd(2'd0, 4'h9, lat, err, rd);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("mid_mode_read", mem_mode, 2'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", rsp_valid, 1'b0);
    check("mid_depth", depth, 5'd0);
    check("mid_empty", empty, 1'b1);
    check("mid_rsp_data", rsp_data, 4'h0);
    check("mid_addr", mem_addr, 4'h0);
    saw = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    rst_n = 1'b1;
    #1;
`ifdef STACK_MEM_CTRL_CLEAR_ON_RESET_EN
    check("init_mode", mem_mode, 2'd1);
    check("init_ready", cmd_ready, 1'b0);
    @(negedge clk);
    check("init_done_ready", cmd_ready, 1'b1);
    check("init_done_mode", mem_mode, 2'd0);
`else
    check("rel_ready", cmd_ready, 1'b1);
    check("rel_mode", mem_mode, 2'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    check("mid_no_rsp", saw, 1'b0);
    do_cmd(2'd1, 4'h0, lat, err, rd);
    check("post_rst_pop_err", err, 1); check("post_rst_pop_lat", lat, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
